// File: rtl/bolme_birimi_pkg.sv
// Shared definitions for the iterative divider: operation codes, FSM states and decode helpers.
package bolme_birimi_pkg;

    localparam logic [1:0] BOLME_DIV  = 2'b00;
    localparam logic [1:0] BOLME_DIVU = 2'b01;
    localparam logic [1:0] BOLME_REM  = 2'b10;
    localparam logic [1:0] BOLME_REMU = 2'b11;

    typedef enum logic [2:0] {
        BOLME_BOSTA   = 3'd0,
        BOLME_MUTLAK1 = 3'd1,
        BOLME_MUTLAK2 = 3'd2,
        BOLME_BOL     = 3'd3,
        BOLME_DUZELT  = 3'd4,
        BOLME_BITTI   = 3'd5
    } durum_t;

    function automatic logic isaretli_mi(input logic [1:0] islem);
        return (islem == BOLME_DIV) || (islem == BOLME_REM);
    endfunction

    function automatic logic kalan_secilir(input logic [1:0] islem);
        return (islem == BOLME_REM) || (islem == BOLME_REMU);
    endfunction

endpackage

// File: rtl/bolme_birimi_if.sv
// Request/result bundle of the divider. Handshake: basla_i is a one-cycle request taken only
// while idle; mesgul_o covers the busy window and bitti_o pulses once when sonuc_o is valid.
interface bolme_birimi_if #(parameter int VERI_BIT = 32);
    logic                basla_i;
    logic [1:0]          islem_i;
    logic [VERI_BIT-1:0] deger1_i;
    logic [VERI_BIT-1:0] deger2_i;
    logic                mesgul_o;
    logic                bitti_o;
    logic [VERI_BIT-1:0] sonuc_o;

    modport master (output basla_i, islem_i, deger1_i, deger2_i,
                    input  mesgul_o, bitti_o, sonuc_o);
    modport slave  (input  basla_i, islem_i, deger1_i, deger2_i,
                    output mesgul_o, bitti_o, sonuc_o);
endinterface

// File: rtl/bolme_birimi_onbellek.sv
// Single-entry result cache for the divider, used when BOLME_ONBELLEK_EN is defined.
// Stores operands, signedness and the uncorrected quotient/remainder of the last op.
module bolme_onbellek #(parameter int VERI_BIT = 32) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                yaz_anahtar_i,
    input  logic                yaz_sonuc_i,
    input  logic [VERI_BIT-1:0] deger1_i,
    input  logic [VERI_BIT-1:0] deger2_i,
    input  logic                isaretli_i,
    input  logic [VERI_BIT-1:0] bolum_i,
    input  logic [VERI_BIT-1:0] kalan_i,
    output logic                isabet_o,
    output logic [VERI_BIT-1:0] bolum_o,
    output logic [VERI_BIT-1:0] kalan_o
);
    logic [VERI_BIT-1:0] anahtar1, anahtar2;
    logic                anahtar_isaretli;
    logic                gecerli;

    // The key is captured at acceptance and validated only once the results land.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            anahtar1         <= '0;
            anahtar2         <= '0;
            anahtar_isaretli <= 1'b0;
            gecerli          <= 1'b0;
            bolum_o          <= '0;
            kalan_o          <= '0;
        end else if (yaz_anahtar_i) begin
            anahtar1         <= deger1_i;
            anahtar2         <= deger2_i;
            anahtar_isaretli <= isaretli_i;
            gecerli          <= 1'b0;
        end else if (yaz_sonuc_i) begin
            bolum_o <= bolum_i;
            kalan_o <= kalan_i;
            gecerli <= 1'b1;
        end
    end

    assign isabet_o = gecerli && (anahtar1 == deger1_i) && (anahtar2 == deger2_i)
                      && (anahtar_isaretli == isaretli_i);
endmodule

// File: rtl/bolme_birimi.sv
// Restoring radix-2 divider for DIV/DIVU/REM/REMU driving the shared execute-stage adder.
// Optional BOLME_ONBELLEK_EN adds a last-result cache that skips straight to correction on a hit.
module bolme_birimi
    import bolme_birimi_pkg::*;
#(
    parameter int VERI_BIT = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    bolme_birimi_if.slave     bus,
    output logic [VERI_BIT:0] top_deger1_o,
    output logic [VERI_BIT:0] top_deger2_o,
    output logic              top_elde_o,
    input  logic [VERI_BIT:0] top_sonuc_i,
    output durum_t            durum_o
);
    localparam logic [5:0] SON_ADIM = 6'(VERI_BIT - 1);

    durum_t              durum, durum_sonraki;
    logic [VERI_BIT-1:0] bolunen, bolen, kalan, sonuc;
    logic [1:0]          islem;
    logic                isaret1, isaret2;
    logic [5:0]          sayac;

    logic [VERI_BIT:0]   kaydirilan;
    logic [VERI_BIT-1:0] secili;
    logic                duzelt_neg;
    logic                kabul;
    logic                isabet;
    logic [VERI_BIT-1:0] onb_bolum, onb_kalan;

    assign kabul      = (durum == BOLME_BOSTA) && bus.basla_i;
    assign kaydirilan = {kalan, bolunen[VERI_BIT-1]};
    assign secili     = kalan_secilir(islem) ? kalan : bolunen;
    // A zero divisor already yields all ones; negating it would break the RV32M result.
    assign duzelt_neg = kalan_secilir(islem) ? isaret1
                                             : ((isaret1 ^ isaret2) && (bolen != '0));

`ifdef BOLME_ONBELLEK_EN
    bolme_onbellek #(.VERI_BIT(VERI_BIT)) u_onbellek (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .yaz_anahtar_i (kabul),
        .yaz_sonuc_i   (durum == BOLME_DUZELT),
        .deger1_i      (bus.deger1_i),
        .deger2_i      (bus.deger2_i),
        .isaretli_i    (isaretli_mi(bus.islem_i)),
        .bolum_i       (bolunen),
        .kalan_i       (kalan),
        .isabet_o      (isabet),
        .bolum_o       (onb_bolum),
        .kalan_o       (onb_kalan)
    );
`else
    assign isabet    = 1'b0;
    assign onb_bolum = '0;
    assign onb_kalan = '0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) durum <= BOLME_BOSTA;
        else       durum <= durum_sonraki;
    end

    always_comb begin
        durum_sonraki = durum;
        case (durum)
            BOLME_BOSTA:   if (bus.basla_i) durum_sonraki = isabet ? BOLME_DUZELT : BOLME_MUTLAK1;
            BOLME_MUTLAK1: durum_sonraki = BOLME_MUTLAK2;
            BOLME_MUTLAK2: durum_sonraki = BOLME_BOL;
            BOLME_BOL:     if (sayac == SON_ADIM) durum_sonraki = BOLME_DUZELT;
            BOLME_DUZELT:  durum_sonraki = BOLME_BITTI;
            BOLME_BITTI:   durum_sonraki = BOLME_BOSTA;
            default:       durum_sonraki = BOLME_BOSTA;
        endcase
    end

    // Every adder use is a subtraction or negation: A + ~B + 1.
    always_comb begin
        top_deger1_o = '0;
        top_deger2_o = '0;
        top_elde_o   = 1'b0;
        bus.mesgul_o = 1'b0;
        bus.bitti_o  = 1'b0;
        case (durum)
            BOLME_MUTLAK1: begin
                bus.mesgul_o = 1'b1;
                if (isaret1) begin
                    top_deger2_o = ~{1'b0, bolunen};
                    top_elde_o   = 1'b1;
                end
            end
            BOLME_MUTLAK2: begin
                bus.mesgul_o = 1'b1;
                if (isaret2) begin
                    top_deger2_o = ~{1'b0, bolen};
                    top_elde_o   = 1'b1;
                end
            end
            BOLME_BOL: begin
                bus.mesgul_o = 1'b1;
                top_deger1_o = kaydirilan;
                top_deger2_o = ~{1'b0, bolen};
                top_elde_o   = 1'b1;
            end
            BOLME_DUZELT: begin
                bus.mesgul_o = 1'b1;
                if (duzelt_neg) begin
                    top_deger2_o = ~{1'b0, secili};
                    top_elde_o   = 1'b1;
                end
            end
            BOLME_BITTI: bus.bitti_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bolunen <= '0;
            bolen   <= '0;
            kalan   <= '0;
            sonuc   <= '0;
            islem   <= 2'b00;
            isaret1 <= 1'b0;
            isaret2 <= 1'b0;
            sayac   <= '0;
        end else begin
            case (durum)
                BOLME_BOSTA: if (bus.basla_i) begin
                    islem   <= bus.islem_i;
                    isaret1 <= isaretli_mi(bus.islem_i) & bus.deger1_i[VERI_BIT-1];
                    isaret2 <= isaretli_mi(bus.islem_i) & bus.deger2_i[VERI_BIT-1];
                    bolunen <= isabet ? onb_bolum : bus.deger1_i;
                    kalan   <= isabet ? onb_kalan : '0;
                    bolen   <= bus.deger2_i;
                    sayac   <= '0;
                end
                BOLME_MUTLAK1: if (isaret1) bolunen <= top_sonuc_i[VERI_BIT-1:0];
                BOLME_MUTLAK2: if (isaret2) bolen   <= top_sonuc_i[VERI_BIT-1:0];
                BOLME_BOL: begin
                    // Sign bit of the trial difference set means it went negative: restore.
                    kalan   <= top_sonuc_i[VERI_BIT] ? kaydirilan[VERI_BIT-1:0]
                                                     : top_sonuc_i[VERI_BIT-1:0];
                    bolunen <= {bolunen[VERI_BIT-2:0], ~top_sonuc_i[VERI_BIT]};
                    sayac   <= sayac + 6'd1;
                end
                BOLME_DUZELT: sonuc <= duzelt_neg ? top_sonuc_i[VERI_BIT-1:0] : secili;
                default: ;
            endcase
        end
    end

    assign bus.sonuc_o = sonuc;
    assign durum_o     = durum;
endmodule

// File: tb/tb_bolme_birimi.sv
// Self-checking bench for bolme_birimi: RV32M reference arithmetic plus a per-cycle monitor.
// Honours BOLME_ONBELLEK_EN by modelling the expected cache-hit latency.
module tb_bolme_birimi;
  import bolme_birimi_pkg::*;

  localparam int W = 32;
`ifdef BOLME_ONBELLEK_EN
  localparam int HIT_LAT = 2;
`else
  localparam int HIT_LAT = 36;
`endif
  localparam int FULL_LAT = 36;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [W:0] top_d1, top_d2, top_s;
  logic top_e;
  durum_t durum;

  int total = 0;
  int bad = 0;

  bolme_birimi_if #(.VERI_BIT(W)) bus ();

  bolme_birimi #(.VERI_BIT(W)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .top_deger1_o(top_d1), .top_deger2_o(top_d2), .top_elde_o(top_e),
    .top_sonuc_i(top_s), .durum_o(durum)
  );

  // Shared execute-stage adder.
  assign top_s = top_d1 + top_d2 + {{W{1'b0}}, top_e};

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    logic ovf;
    sa = a;
    sb = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      2'b00:   return (b == 0) ? '1 : (ovf ? a : W'(sa / sb));
      2'b01:   return (b == 0) ? '1 : a / b;
      2'b10:   return (b == 0) ? a : (ovf ? '0 : W'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] exp_q[$];
  bit m_busy = 0;
  bit was_busy;
  int m_cnt = 0;
  int m_lat = 0;
  logic [W-1:0] m_sonuc = '0;
  bit c_valid = 0;
  logic [W-1:0] c_a, c_b, cur_a, cur_b;
  bit c_sgn, cur_sgn, sgn, hit;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0;
      m_cnt = 0;
      m_sonuc = '0;
      c_valid = 0;
      exp_q.delete();
    end else begin
      was_busy = m_busy;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == m_lat) begin
          chk("bitti_pulse", bus.bitti_o, 1);
          chk("mesgul_low_at_bitti", bus.mesgul_o, 0);
          if (exp_q.size() > 0) m_sonuc = exp_q.pop_front();
          m_busy = 0;
          c_valid = 1;
          c_a = cur_a;
          c_b = cur_b;
          c_sgn = cur_sgn;
        end else begin
          chk("mesgul_busy", bus.mesgul_o, 1);
          chk("bitti_early", bus.bitti_o, 0);
        end
      end else begin
        chk("mesgul_idle", bus.mesgul_o, 0);
        chk("bitti_idle", bus.bitti_o, 0);
      end
      if (!m_busy) begin
        chk("top_d1_idle", top_d1, 0);
        chk("top_d2_idle", top_d2, 0);
        chk("top_e_idle", top_e, 0);
      end
      chk("sonuc", bus.sonuc_o, m_sonuc);
      if (!was_busy && bus.basla_i) begin
        sgn = (bus.islem_i == 2'b00) || (bus.islem_i == 2'b10);
`ifdef BOLME_ONBELLEK_EN
        hit = c_valid && (bus.deger1_i == c_a) && (bus.deger2_i == c_b) && (sgn == c_sgn);
`else
        hit = 0;
`endif
        exp_q.push_back(ref_op(bus.islem_i, bus.deger1_i, bus.deger2_i));
        m_lat = hit ? 2 : FULL_LAT;
        m_busy = 1;
        m_cnt = 0;
        c_valid = 0;
        cur_a = bus.deger1_i;
        cur_b = bus.deger2_i;
        cur_sgn = sgn;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    tick();
    bus.basla_i = 1'b1;
    bus.islem_i = op;
    bus.deger1_i = a;
    bus.deger2_i = b;
    tick();
    bus.basla_i = 1'b0;
  endtask

  // Returns the cycle index (acceptance edge is followed by cycle 1) of bitti_o, 0 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (bus.bitti_o) begin
        lat = i + 1;
        break;
      end
    end
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] lit, input int exp_lat);
    int lat;
    start_op(op, a, b);
    wait_done(lat);
    chk({name, "_lat"}, lat, exp_lat);
    chk(name, bus.sonuc_o, lit);
  endtask

  function automatic logic [W-1:0] pick_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return W'($urandom_range(0, 20));
      4: return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat, seen;
    bus.basla_i = 1'b0;
    bus.islem_i = 2'b00;
    bus.deger1_i = '0;
    bus.deger2_i = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_sonuc", bus.sonuc_o, 0);
    chk("rst_mesgul", bus.mesgul_o, 0);
    chk("rst_bitti", bus.bitti_o, 0);
    chk("rst_durum", durum, BOLME_BOSTA);
    chk("rst_top", top_d1, 0);

    do_op("divu_100_7", 2'b01, 100, 7, 14, FULL_LAT);
    do_op("remu_100_7", 2'b11, 100, 7, 2, HIT_LAT);
    do_op("div_m7_2", 2'b00, -32'sd7, 2, 32'hFFFF_FFFD, FULL_LAT);
    do_op("rem_m7_2", 2'b10, -32'sd7, 2, 32'hFFFF_FFFF, HIT_LAT);
    do_op("rem_7_m2", 2'b10, 7, -32'sd2, 1, FULL_LAT);
    do_op("div_5_0", 2'b00, 5, 0, 32'hFFFF_FFFF, FULL_LAT);
    do_op("remu_5_0", 2'b11, 5, 0, 5, FULL_LAT);
    do_op("div_m5_0", 2'b00, -32'sd5, 0, 32'hFFFF_FFFF, FULL_LAT);
    do_op("rem_m5_0", 2'b10, -32'sd5, 0, 32'hFFFF_FFFB, HIT_LAT);
    do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, FULL_LAT);
    do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, HIT_LAT);
    do_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, FULL_LAT);

`ifdef BOLME_ONBELLEK_EN
    do_op("c_div_100_7", 2'b00, 100, 7, 14, FULL_LAT);
    do_op("c_rem_100_7", 2'b10, 100, 7, 2, 2);
    do_op("c_divu_100_7", 2'b01, 100, 7, 14, FULL_LAT);
`endif

    // A second request while busy must be dropped.
    start_op(2'b01, 100, 7);
    repeat (9) tick();
    bus.basla_i = 1'b1;
    bus.islem_i = 2'b10;
    bus.deger1_i = 123;
    bus.deger2_i = 5;
    tick();
    bus.basla_i = 1'b0;
    wait_done(lat);
    chk("repulse_done", lat != 0, 1);
    chk("repulse_sonuc", bus.sonuc_o, 14);
    tick();
    chk("repulse_idle", bus.mesgul_o, 0);

    // Reset in the middle of an operation aborts without a completion pulse.
    start_op(2'b00, 1000, 3);
    repeat (18) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.bitti_o) seen++;
    end
    chk("abort_no_bitti", seen, 0);
    chk("abort_sonuc", bus.sonuc_o, 0);
    chk("abort_mesgul", bus.mesgul_o, 0);
    do_op("after_abort", 2'b00, 1000, 3, 333, FULL_LAT);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] op;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a = pick_val();
      b = pick_val();
      if ($urandom_range(0, 3) == 0) op = op ^ 2'b10;
      start_op(op, a, b);
      wait_done(lat);
      chk("rand_done", lat != 0, 1);
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bolme_birimi.md
Name: bolme_birimi

Overview:
Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the yurut stage. It owns no adder of its own. Each cycle it drives the shared execute-stage carry-lookahead adder (instantiated with BIT=VERI_BIT+1) through the top_* ports and registers what comes back. It is a multi-cycle unit: it stalls the pipe via mesgul_o and delivers one result with a bitti_o pulse.

Parameters:
VERI_BIT, 32, operand/result width; adder path is VERI_BIT+1 wide.

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous, active-high reset
basla_i  input  1  start request; accepted only in BOSTA
islem_i  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with basla_i
deger1_i  input  VERI_BIT  dividend; sampled with basla_i
deger2_i  input  VERI_BIT  divisor; sampled with basla_i
mesgul_o  output  1  high from the cycle after acceptance until bitti_o
bitti_o  output  1  one-cycle pulse, sonuc_o valid
sonuc_o  output  VERI_BIT  result; held until next acceptance
top_deger1_o  output  VERI_BIT+1  adder operand A
top_deger2_o  output  VERI_BIT+1  adder operand B
top_elde_o  output  1  adder carry-in
top_sonuc_i  input  VERI_BIT+1  adder sum, combinational same cycle

Behaviour:
- Reset: state BOSTA; mesgul_o=0, bitti_o=0, sonuc_o=0; all internal registers 0. rst_i mid-operation aborts immediately with no bitti_o.
- When idle (BOSTA/BITTI), top_* outputs are 0.
- States: BOSTA -> MUTLAK1 -> MUTLAK2 -> BOL (VERI_BIT cycles) -> DUZELT -> BITTI -> BOSTA.
- BOSTA:
  - basla_i=1 latches operands, islem_i and sign flags. Signed ops: sign = operand MSB. Unsigned ops: sign = 0.
  - basla_i is ignored in every other state.
- MUTLAK1: if the dividend sign is set, dividend <= top_sonuc_i with A=0, B=~{0,dividend}, elde=1. Otherwise hold.
- MUTLAK2: same rule for the divisor.
- BOL, per cycle:
  - kaydirilan = {kalan[VERI_BIT-1:0], bolunen[VERI_BIT-1]}.
  - Drive A=kaydirilan, B=~{0,bolen}, elde=1.
  - If top_sonuc_i[VERI_BIT]=0: kalan <= top_sonuc_i[VERI_BIT-1:0], quotient bit=1. Otherwise kalan <= kaydirilan, bit=0.
  - bolunen shifts left, quotient bit enters at the LSB.
  - A 6-bit counter ends the state after exactly VERI_BIT iterations.
- DUZELT:
  - Select quotient (DIV/DIVU) or remainder (REM/REMU).
  - Negate via adder (A=0, B=~sel, elde=1) when required:
    - Quotient: negate when dividend sign XOR divisor sign, and divisor != 0.
    - Remainder: negate when dividend sign.
  - Register the result into sonuc_o.
- BITTI: bitti_o=1 for exactly this cycle, mesgul_o=0; return to BOSTA. basla_i in BITTI is ignored.
- Latency: basla_i accepted at edge k gives bitti_o high in cycle k+VERI_BIT+4 (36 for VERI_BIT=32).
- Boundary cases, with no special-case logic:
  - Divide by zero: quotient = all ones (unsigned and signed), remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient 0x80000000, remainder 0.
  - An operand of 0 passes through the MUTLAK states unchanged.

Optional Feature:
BOLME_ONBELLEK_EN:
- Defined: keeps the last completed op's operands, signedness and unsigned quotient/remainder (pre-correction), plus a valid bit.
- valid is cleared by rst_i and set on every completed op.
- Hit condition: new op has equal operands and equal signedness (DIV/REM or DIVU/REMU pairing allowed), and valid=1.
- On a hit: BOSTA -> DUZELT -> BITTI, so bitti_o arrives at k+2. Results are identical to a full run.
- Undefined: no storage, every op takes the full latency.

Decomposition:
- tanimlamalar.vh carries:
  - islem codes: BOLME_DIV, BOLME_DIVU, BOLME_REM, BOLME_REMU.
  - State encodings: BOLME_BOSTA, BOLME_MUTLAK1, BOLME_MUTLAK2, BOLME_BOL, BOLME_DUZELT, BOLME_BITTI.
- Single module otherwise. If BOLME_ONBELLEK_EN is used, the cache is the natural sub-module: bolme_onbellek (compare + storage, hit output).

Test Plan:
- DIVU 100/7 -> sonuc_o=14 at cycle k+36; REMU same operands -> 2. mesgul_o high cycles k+1..k+35.
- DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV -5/0 -> 0xFFFFFFFF; REM -5/0 -> 0xFFFFFFFB.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF.
- basla_i re-pulsed at k+10 with other operands -> ignored, first result unchanged. rst_i at k+20 -> no bitti_o, outputs 0, next op correct.
- BOLME_ONBELLEK_EN: DIV 100/7, then REM 100/7 -> 2 at k+2. DIVU 100/7 afterwards -> full 36-cycle latency (signedness miss).
